// File: rtl/bus_fill_checker_pkg.sv
// Shared widths and state encoding for the bus fill checker.
package bus_fill_checker_pkg;

  localparam int WIDTH = 10;
  localparam int IDX_W = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

endpackage

// File: rtl/bus_fill_checker_edge.sv
// Two-stage bus sampler producing the current sample plus per-bit rise/fall.
module bus_edge_detect #(
  parameter int WIDTH = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] i_bus,
  output logic [WIDTH-1:0] o_bus_s,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_primed
);

  logic [WIDTH-1:0] r_bus_s;
  logic [WIDTH-1:0] r_bus_p;
  logic             r_primed;

  // r_primed marks that r_bus_s holds a real sample rather than the reset zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_bus_s  <= '0;
      r_bus_p  <= '0;
      r_primed <= 1'b0;
    end else begin
      r_bus_s  <= i_bus;
      r_bus_p  <= r_bus_s;
      r_primed <= 1'b1;
    end
  end

  assign o_bus_s  = r_bus_s;
  assign o_rise   = r_bus_s & ~r_bus_p;
  assign o_fall   = r_bus_p & ~r_bus_s;
  assign o_primed = r_primed;

endmodule

// File: rtl/bus_fill_checker.sv
// Checks an LSB-first one-bit-per-clock bus fill, strobing each new bit index
// and flagging completion or a sticky protocol error.
module bus_fill_checker
  import bus_fill_checker_pkg::*;
#(
  parameter int WIDTH = bus_fill_checker_pkg::WIDTH,
  parameter int IDX_W = bus_fill_checker_pkg::IDX_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] BUS_IN,
  input  logic             CLR_IN,
  output logic             IDX_VALID,
  output logic [IDX_W-1:0] IDX_OUT,
  output logic [IDX_W-1:0] FILL_CNT,
  output logic             FILL_DONE,
  output logic             SEQ_ERR,
  output logic [1:0]       DBG_STATE
);

  logic [WIDTH-1:0] w_bus_s;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic             w_primed;
  logic             w_exp_hit;
  logic             w_last;

  state_t           r_state;
  logic [IDX_W-1:0] r_exp;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_cnt;
  logic             r_valid;
  logic             r_done;
  logic             r_err;

  bus_edge_detect #(.WIDTH(WIDTH)) u_edge (
    .CLK      (CLK),
    .RST      (RST),
    .i_bus    (BUS_IN),
    .o_bus_s  (w_bus_s),
    .o_rise   (w_rise),
    .o_fall   (w_fall),
    .o_primed (w_primed)
  );

  assign w_exp_hit = (w_rise == (WIDTH'(1) << r_exp));
  assign w_last    = (r_exp == IDX_W'(WIDTH - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_exp   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (CLR_IN) begin
        r_state <= ST_IDLE;
        r_exp   <= '0;
        r_cnt   <= '0;
        r_done  <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // Only a genuinely sampled empty bus arms tracking.
            if (w_primed && (w_bus_s == '0)) begin
              r_state <= ST_TRACK;
              r_exp   <= '0;
              r_cnt   <= '0;
            end
          end
          ST_TRACK: begin
            if (w_fall != '0) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end else if (w_rise != '0) begin
              if (w_exp_hit) begin
                r_valid <= 1'b1;
                r_idx   <= r_exp;
                r_cnt   <= r_exp + 1'b1;
                if (w_last) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_exp <= r_exp + 1'b1;
                end
              end else begin
                r_state <= ST_ERR;
                r_err   <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            if (w_bus_s == '0) begin
              r_state <= ST_TRACK;
              r_exp   <= '0;
              r_cnt   <= '0;
              r_done  <= 1'b0;
            end else if (w_fall != '0) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
          ST_ERR: begin
            r_err <= 1'b1;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign IDX_VALID = r_valid;
  assign IDX_OUT   = r_idx;
  assign FILL_CNT  = r_cnt;
  assign FILL_DONE = r_done;
  assign SEQ_ERR   = r_err;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_bus_fill_checker.sv
// Randomised and directed bench for bus_fill_checker with a frame-level model
// and a strobe scoreboard.
module tb_bus_fill_checker;
  import bus_fill_checker_pkg::*;

  localparam int W = WIDTH;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [W-1:0]     BUS_IN = '0;
  logic             CLR_IN = 1'b0;
  logic             IDX_VALID;
  logic [IDX_W-1:0] IDX_OUT;
  logic [IDX_W-1:0] FILL_CNT;
  logic             FILL_DONE;
  logic             SEQ_ERR;
  logic [1:0]       DBG_STATE;

  int checks = 0;
  int errors = 0;

  logic [IDX_W-1:0] exp_q[$];

  // Model: 0 waiting for empty bus, 1 filling, 2 full, 3 faulted.
  int  m_mode = 0;
  int  m_cnt = 0;
  int  m_prev = 0;
  bit  m_done = 0;
  bit  m_err = 0;
  bit  m_have_last = 0;
  int  last_v = 0;

  always #5 CLK = ~CLK;

  bus_fill_checker dut (
    .CLK       (CLK),
    .RST       (RST),
    .BUS_IN    (BUS_IN),
    .CLR_IN    (CLR_IN),
    .IDX_VALID (IDX_VALID),
    .IDX_OUT   (IDX_OUT),
    .FILL_CNT  (FILL_CNT),
    .FILL_DONE (FILL_DONE),
    .SEQ_ERR   (SEQ_ERR),
    .DBG_STATE (DBG_STATE)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int mask(input int n);
    return (1 << n) - 1;
  endfunction

  // Frame rules: a filling bus may only stay put or grow to the next LSB-first mask.
  task automatic model_eval(input int v, input bit c);
    if (c) begin
      m_mode = 0; m_cnt = 0; m_done = 0; m_err = 0;
    end else begin
      case (m_mode)
        0: if (v == 0) begin m_mode = 1; m_cnt = 0; end
        1: if (v != m_prev) begin
             if (v == mask(m_cnt + 1)) begin
               exp_q.push_back(IDX_W'(m_cnt));
               m_cnt++;
               if (m_cnt == W) begin m_mode = 2; m_done = 1; end
             end else begin
               m_mode = 3; m_err = 1;
             end
           end
        2: if (v == 0) begin
             m_mode = 1; m_cnt = 0; m_done = 0;
           end else if (v != m_prev) begin
             m_mode = 3; m_err = 1;
           end
        default: ;
      endcase
    end
    m_prev = v;
  endtask

  task automatic step(input int v, input bit c);
    BUS_IN = W'(v);
    CLR_IN = c;
    if (m_have_last) model_eval(last_v, c);
    m_have_last = 1;
    last_v = v;
    @(posedge CLK);
    #1;
    check("fill_cnt", int'(FILL_CNT), m_cnt);
    check("fill_done", int'(FILL_DONE), int'(m_done));
    check("seq_err", int'(SEQ_ERR), int'(m_err));
    check("state", int'(DBG_STATE), m_mode);
  endtask

  // Asserts reset between edges and checks outputs drop without a clock edge.
  task automatic do_reset(input int v);
    #5;
    check("strobes_drained", exp_q.size(), 0);
    RST = 1'b1;
    BUS_IN = W'(v);
    CLR_IN = 1'b0;
    #1;
    check("rst_valid", int'(IDX_VALID), 0);
    check("rst_idx", int'(IDX_OUT), 0);
    check("rst_cnt", int'(FILL_CNT), 0);
    check("rst_done", int'(FILL_DONE), 0);
    check("rst_err", int'(SEQ_ERR), 0);
    m_mode = 0; m_cnt = 0; m_prev = 0; m_done = 0; m_err = 0;
    m_have_last = 0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic restart();
    step(0, 1'b1);
    step(0, 1'b0);
    step(0, 1'b0);
  endtask

  task automatic fill(input int n, input int hold_max);
    for (int i = 1; i <= n; i++) begin
      int reps;
      reps = 1 + $urandom_range(0, hold_max);
      for (int r = 0; r < reps; r++) step(mask(i), 1'b0);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && IDX_VALID) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: idx %0d, expected no strobe at %0t", IDX_OUT, $time);
      end else begin
        logic [IDX_W-1:0] e;
        e = exp_q.pop_front();
        check("idx_out", int'(IDX_OUT), int'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    do_reset(0);
    // Full in-order fill.
    step(0, 1'b0); step(0, 1'b0);
    fill(W, 0);
    step(mask(W), 1'b0); step(mask(W), 1'b0);
    // New frame from DONE, partial refill.
    step(0, 1'b0); step(0, 1'b0);
    step(1, 1'b0); step(3, 1'b0); step(3, 1'b0); step(3, 1'b0);
    // Skipped bit, then error persists while bits keep filling.
    restart();
    step(1, 1'b0); step(5, 1'b0);
    for (int i = 3; i <= W; i++) step(mask(i), 1'b0);
    step(mask(W), 1'b1);
    step(mask(W), 1'b0);
    // Two bits at once.
    restart();
    step(3, 1'b0); step(3, 1'b0); step(3, 1'b0);
    // Falling bit after three strobes.
    restart();
    step(1, 1'b0); step(3, 1'b0); step(7, 1'b0); step(7, 1'b0);
    step(5, 1'b0); step(5, 1'b0); step(5, 1'b0);
    // Full bus out of reset is ignored until it clears.
    do_reset(mask(W));
    repeat (4) step(mask(W), 1'b0);
    step(0, 1'b0); step(0, 1'b0);
    fill(W, 0);
    step(mask(W), 1'b0); step(mask(W), 1'b0);
    // Async reset after five strobes.
    restart();
    fill(5, 0);
    step(mask(5), 1'b0);
    do_reset(0);
    // Clear coinciding with a correct rise.
    step(0, 1'b0); step(0, 1'b0);
    step(1, 1'b0); step(1, 1'b1);
    step(1, 1'b0); step(1, 1'b0);
    // Randomised frames with occasional corruption and back-to-back refills.
    for (int t = 0; t < 30; t++) begin
      int n;
      restart();
      n = $urandom_range(1, W);
      fill(n, 2);
      if ($urandom_range(0, 2) == 0) begin
        step($urandom_range(0, mask(W)), 1'b0);
        step(m_prev, 1'b0);
        fill(W, 0);
      end else if (n == W) begin
        step(mask(W), 1'b0);
        step(0, 1'b0);
        fill($urandom_range(1, W), 1);
      end
      step(last_v, 1'b0);
      step(last_v, 1'b0);
    end
    restart();
    #5;
    check("strobes_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_fill_checker.md
Name: bus_fill_checker

Overview:
Receiving end of the one-hot-per-cycle bus fill pattern: the generator sets one bit of a 10-bit bus per clock, LSB first, and bits stay set. This block samples that bus and reports each newly set bit as an index with a one-cycle valid strobe. It also counts the fill, flags completion, and raises a sticky error on any out-of-order, multi-bit or falling transition. It sits on the bus test path as the self-check for the generator.

Parameters:
WIDTH, 10, bus width; number of bits in one fill frame
IDX_W, 4, index/count width; must satisfy 2**IDX_W > WIDTH

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
BUS_IN  input  WIDTH  monitored bus, synchronous to CLK
CLR_IN  input  1  synchronous restart; clears error and returns to IDLE
IDX_VALID  output  1  one-cycle strobe: IDX_OUT holds a correctly ordered new bit
IDX_OUT  output  IDX_W  index of the bit just set (0..WIDTH-1)
FILL_CNT  output  IDX_W  bits accepted in the current frame (0..WIDTH)
FILL_DONE  output  1  level; all WIDTH bits set in order
SEQ_ERR  output  1  sticky protocol error

Behaviour:
- Reset (async, RST=1): bus_s=0, bus_p=0, state=IDLE, exp=0. All outputs are 0.
- Sampling: bus_s <= BUS_IN; bus_p <= bus_s; rise = bus_s & ~bus_p; fall = bus_p & ~bus_s.
- Latency: a bit present before edge k is in bus_s after k. IDX_VALID/IDX_OUT/FILL_CNT update after edge k+1 (2 cycles).
- States: IDLE, TRACK, DONE, ERR; 2-bit encoding.
- IDLE:
  - rise/fall ignored; IDX_VALID=0.
  - bus_s==0 -> TRACK with exp=0, FILL_CNT=0.
  - A bus already non-zero out of reset keeps the block in IDLE until the bus clears.
- TRACK:
  - rise==0 and fall==0: hold.
  - fall!=0: -> ERR.
  - rise == (1<<exp): IDX_VALID=1, IDX_OUT=exp, FILL_CNT=exp+1, exp=exp+1.
    - If exp==WIDTH-1: -> DONE with FILL_DONE=1 in the same cycle as the final strobe.
  - Any other rise (wrong bit, or more than one bit): -> ERR, no strobe.
- DONE:
  - FILL_DONE held at 1.
  - bus_s==0: -> TRACK with exp=0, FILL_CNT=0, FILL_DONE=0 (new frame).
  - Any other fall: -> ERR. Rise is impossible because the bus is full.
- ERR:
  - SEQ_ERR=1 and IDX_VALID=0 until CLR_IN or RST.
  - FILL_CNT and FILL_DONE freeze at their values when the error occurred.
- CLR_IN=1 (synchronous, highest priority after RST):
  - next state IDLE; exp, FILL_CNT, FILL_DONE, SEQ_ERR cleared.
  - A rise in the same cycle is discarded.
- exp never exceeds WIDTH-1; index arithmetic is unsigned IDX_W bits with no wrap.
- IDX_OUT holds its last value when IDX_VALID=0.
- RST asserted mid-frame drops all outputs immediately, without waiting for a clock edge.

Decomposition:
- Shared package/header:
  - WIDTH default
  - IDX_W
  - state encoding constants ST_IDLE=0, ST_TRACK=1, ST_DONE=2, ST_ERR=3
- Sub-module bus_edge_detect:
  - contains the 2-stage register with async reset
  - outputs bus_s, rise, fall
- The checker FSM and counters live in bus_fill_checker.

Test Plan:
- RST pulse; BUS_IN=0 for 2 clk; then set bits 0..9 one per clk -> 10 IDX_VALID strobes, IDX_OUT 0..9 in consecutive cycles; FILL_CNT ends at 10; FILL_DONE=1 with the last strobe; SEQ_ERR=0.
- After DONE, BUS_IN=0x000, then refill 0x001, 0x003 -> FILL_DONE drops; strobes IDX_OUT=0,1; FILL_CNT=2.
- From 0x000: 0x001 then 0x005 (skip bit1) -> one strobe (idx 0), then SEQ_ERR=1; no further strobes while bits 1..9 fill; CLR_IN pulse -> SEQ_ERR=0, state IDLE.
- From 0x000: 0x003 in one cycle -> SEQ_ERR=1, no strobe. Separately: 0x001, 0x003, 0x007, then 0x005 (falling bit1) -> 3 strobes, then SEQ_ERR=1, FILL_CNT frozen at 3.
- Release reset with BUS_IN=0x3FF -> no strobes, no error, FILL_DONE=0; then BUS_IN=0x000 and a full fill -> normal 10 strobes.
- RST asserted asynchronously after 5 strobes -> all outputs 0 before the next edge. Separately: CLR_IN=1 in the same cycle a correct rise is sampled -> no strobe, FILL_CNT=0.
